// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arbiter_pkg;

  // Arbiter FSM: IDLE arbitrates, BUSY forwards the granted master.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a master index, never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_idx, wrapping.
module wb_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last_idx,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = N_MASTERS; off >= 1; off--) begin
      cand = int'(last_idx) + off;
      if (cand >= N_MASTERS) begin
        cand = cand - N_MASTERS;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end else begin
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B3 arbiter: N masters share one slave port.
// A grant is held for the whole cyc tenure; responses go to the granted master only.
// Optional watchdog: define WB_ARBITER_TIMEOUT_EN to raise m_err on a hung slave.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [N_MASTERS-1:0]                  m_cyc,
  input  logic [N_MASTERS-1:0]                  m_stb,
  input  logic [N_MASTERS-1:0]                  m_we,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]    m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]    m_dat_w,
  input  logic [N_MASTERS*WB_DATA_WIDTH/8-1:0]  m_sel,
  output logic [WB_DATA_WIDTH-1:0]              m_dat_r,
  output logic [N_MASTERS-1:0]                  m_ack,
  output logic [N_MASTERS-1:0]                  m_err,
  output logic [N_MASTERS-1:0]                  m_gnt,
  output logic                                  s_cyc,
  output logic                                  s_stb,
  output logic                                  s_we,
  output logic [WB_ADDR_WIDTH-1:0]              s_adr,
  output logic [WB_DATA_WIDTH-1:0]              s_dat_w,
  output logic [WB_DATA_WIDTH/8-1:0]            s_sel,
  input  logic [WB_DATA_WIDTH-1:0]              s_dat_r,
  input  logic                                  s_ack,
  input  logic                                  s_err
);

  localparam int IDX_W = idx_width(N_MASTERS);
  localparam int SEL_W = WB_DATA_WIDTH / 8;

  arb_state_e        state;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  last_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              busy;
  logic              gnt_cyc;
  logic              to_fire;

  wb_rr_arbiter #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req      (m_cyc),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign busy    = (state == BUSY);
  assign m_dat_r = s_dat_r;

  // Grant FSM: arbitrate in IDLE, hold the grant while the owner keeps cyc high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= IDX_W'(N_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BUSY;
            gnt_idx  <= pick_idx;
            last_idx <= pick_idx;
          end else begin
            state    <= IDLE;
          end
        end
        BUSY: begin
          if (!gnt_cyc) begin
            state <= IDLE;
          end else begin
            state <= BUSY;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Slave-side mux: follow the granted master in BUSY, drive zeros otherwise.
  always_comb begin
    gnt_cyc = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (busy && (gnt_idx == IDX_W'(i))) begin
        gnt_cyc = m_cyc[i];
        s_cyc   = m_cyc[i];
        s_stb   = m_stb[i] & m_cyc[i];
        s_we    = m_we[i];
        s_adr   = m_adr[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        s_dat_w = m_dat_w[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        s_sel   = m_sel[i*SEL_W +: SEL_W];
      end else begin
        gnt_cyc = gnt_cyc;
      end
    end
  end

  // Response routing and grant status: only the granted master sees ack/err.
  always_comb begin
    m_ack = '0;
    m_err = '0;
    m_gnt = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (busy && (gnt_idx == IDX_W'(i))) begin
        m_gnt[i] = 1'b1;
        m_ack[i] = s_ack;
        m_err[i] = s_err | to_fire;
      end else begin
        m_gnt[i] = 1'b0;
      end
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] to_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive strobed cycle without a slave response.
  assign to_fire = busy & s_stb & ~s_ack & ~s_err & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared outside BUSY, on any response and after firing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (!busy) begin
      to_cnt <= '0;
    end else if (s_ack || s_err || to_fire) begin
      to_cnt <= '0;
    end else if (s_stb) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone (classic, B3) bus arbiter that shares one slave port among N_MASTERS initiators. It sits between multiple Wishbone masters (for example BFMs, DMA engines, or CPU ports) and a single slave such as `wb_slave_bfm`. A grant is held for the whole `cyc` tenure, so multi-beat and locked sequences are never split. The granted master's cycle is forwarded to the slave, and the slave's response is routed back to that master only.

## Interface
Parameters:
- N_MASTERS, 2, number of requesting masters (2..8)
- WB_ADDR_WIDTH, 32, address width
- WB_DATA_WIDTH, 32, data width; select width is WB_DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, watchdog limit; used only when WB_ARBITER_TIMEOUT_EN is defined

Ports (`i` indexes the masters and selects slice i of each flat vector):
- clk  input  1  single clock for all logic
- rstn  input  1  reset, asynchronous assert, active-low
- m_cyc  input  N_MASTERS  per-master cycle request
- m_stb  input  N_MASTERS  per-master strobe
- m_we  input  N_MASTERS  per-master write enable
- m_adr  input  N_MASTERS*WB_ADDR_WIDTH  per-master address, slice i = master i
- m_dat_w  input  N_MASTERS*WB_DATA_WIDTH  per-master write data
- m_sel  input  N_MASTERS*WB_DATA_WIDTH/8  per-master byte selects
- m_dat_r  output  WB_DATA_WIDTH  read data, broadcast to all masters
- m_ack  output  N_MASTERS  per-master acknowledge
- m_err  output  N_MASTERS  per-master error
- m_gnt  output  N_MASTERS  one-hot current grant (status only)
- s_cyc, s_stb, s_we  output  1 each  to the slave
- s_adr  output  WB_ADDR_WIDTH  to the slave
- s_dat_w  output  WB_DATA_WIDTH  to the slave
- s_sel  output  WB_DATA_WIDTH/8  to the slave
- s_dat_r  input  WB_DATA_WIDTH  from the slave
- s_ack, s_err  input  1 each  from the slave

## Operation
- FSM states: IDLE and BUSY. Registered state: `gnt_idx` and `last_idx`.
- **IDLE, no request** (`m_cyc` all zero): stay in IDLE.
- **IDLE, request present:** pick the first asserted `m_cyc[k]`, searching from index `last_idx+1` upward and wrapping modulo N_MASTERS. Register `gnt_idx=k` and `last_idx=k`, then go to BUSY.
- **BUSY, granted master holds `m_cyc`:** the slave bus follows the granted master.
  - `s_cyc = m_cyc[gnt]`, `s_stb = m_stb[gnt]`, and likewise for `we`, `adr`, `dat_w`, `sel`.
- **BUSY, `m_cyc[gnt]` drops:** go to IDLE.
  - `s_cyc` and `s_stb` are forced to 0 in that same cycle, because they follow `m_cyc[gnt]`.
- **Outputs in IDLE:**
  - `s_cyc`, `s_stb`, `s_we`, `m_gnt` = 0; `s_adr`, `s_dat_w`, `s_sel` = 0.
- **Response routing:**
  - `m_ack[i] = s_ack & (state==BUSY) & (gnt_idx==i)`
  - `m_err[i] = s_err & (state==BUSY) & (gnt_idx==i)`
  - `m_dat_r = s_dat_r` unconditionally.
- **Non-granted masters** see `ack`/`err` = 0 and simply wait; no request is dropped.
- **Stray responses:** an `s_ack` or `s_err` arriving in IDLE is ignored.
- **Reset:** state = IDLE, `gnt_idx` = 0, `last_idx` = N_MASTERS-1 (so master 0 wins first), all outputs 0.
  - Reset asserted mid-transfer aborts it immediately; the slave sees `s_cyc` fall asynchronously.

## Timing
- Request-to-grant latency: `m_cyc` sampled high in IDLE at edge n gives BUSY and `s_cyc` high after edge n (one cycle).
- Slave ack is passed through combinationally to the master: zero added latency per beat.
- Re-arbitration: after `m_cyc[gnt]` falls there is exactly one IDLE cycle before the next grant. Back-to-back tenures are therefore spaced by at least one idle cycle.
- Simultaneous requests in IDLE: round-robin order decides.
- Re-request by the just-served master: it ranks last among the current requesters.
- Release and new request in the same cycle: the release is handled first (go to IDLE); the new request is arbitrated in IDLE.

## Configuration
- Macro: WB_ARBITER_TIMEOUT_EN.
- **Defined:** a counter clears on entry to BUSY and on each `s_ack` or `s_err`.
  - It increments each BUSY cycle with `s_stb=1` and no response.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter pulses `m_err[gnt]` for one cycle (taking precedence over the pass-through) and clears the counter.
  - The grant is held until the master drops `cyc`.
- **Undefined:** no counter; a hung slave stalls the bus indefinitely. TIMEOUT_CYCLES is ignored.

## Structure
- Package `wb_arbiter_pkg`: state enum (IDLE, BUSY) and a function computing `$clog2(N_MASTERS)` with a minimum of 1.
- Sub-module `wb_rr_arbiter`: combinational round-robin pick. Inputs are the request vector and `last_idx`; outputs are `valid` and `idx`.
- Top module holds the FSM, the mux, and the response routing.

## Test plan
- Master 0 alone, single write `adr=0x10`, `dat=0xA5A5A5A5`, slave acks after 2 cycles:
  - `s_cyc` rises 1 cycle after `m_cyc[0]`;
  - `m_ack[0]` pulses once; `m_ack[1]` stays 0.
- Masters 0 and 1 request in the same cycle after reset:
  - master 0 is granted first;
  - master 1 is granted after master 0 drops `cyc` plus 1 idle cycle.
- Master 0 holds `cyc` for a 4-beat burst while master 1 requests:
  - all 4 acks go to master 0;
  - master 1 waits, then is granted.
- Three masters request continuously, with N_MASTERS=3: grant order is 0,1,2,0,1,2; `m_gnt` is one-hot.
- `rstn` asserted mid-burst: all outputs go to 0 immediately; after release, master 0 is granted first.
- Macro defined, TIMEOUT_CYCLES=8, slave never acks: `m_err[gnt]` pulses on the 8th stalled `stb` cycle. Without the macro, no `err` appears after 100 cycles.
